// File: rtl/flash_bus_pkg.sv
// Shared definitions for the NOR flash bus arbiter.
// Holds the sequencer state encoding, default strobe timing, the flash data
// width and the phase counter type used by flash_bus_arb.
package flash_bus_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int CNT_WIDTH     = 4;
  localparam int DEF_ADR_WIDTH = 24;

  localparam int DEF_RD_CYCLES = 6;
  localparam int DEF_WR_SETUP  = 1;
  localparam int DEF_WR_PULSE  = 4;
  localparam int DEF_WR_HOLD   = 1;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WS   = 3'd2,
    ST_WP   = 3'd3,
    ST_WH   = 3'd4,
    ST_ACK  = 3'd5
  } state_e;

  // Converts a cycle-count parameter into a counter reload value.
  function automatic cnt_t phase_len(input int cycles);
    return cnt_t'(cycles);
  endfunction

endpackage

// File: rtl/flash_bus_arb_if.sv
// Master-side handshake bundle of the flash bus arbiter.
// Port 0 (req0/we0/adr0/dw0/ack0) is the JTAG flasher, port 1 the CPU.
// dr is the shared read-data return, rr_ptr shows which port currently
// has round-robin priority.
//   master modport: drives requests, receives ack/dr/rr_ptr
//   slave  modport: the arbiter's view
interface flash_bus_arb_if #(
  parameter int ADR_WIDTH = flash_bus_pkg::DEF_ADR_WIDTH
) ();
  import flash_bus_pkg::*;

  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADR_WIDTH-1:0]  adr0;
  logic [ADR_WIDTH-1:0]  adr1;
  logic [DATA_WIDTH-1:0] dw0;
  logic [DATA_WIDTH-1:0] dw1;
  logic                  ack0;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] dr;
  logic                  rr_ptr;

  modport master (
    output req0, req1, we0, we1, adr0, adr1, dw0, dw1,
    input  ack0, ack1, dr, rr_ptr
  );

  modport slave (
    input  req0, req1, we0, we1, adr0, adr1, dw0, dw1,
    output ack0, ack1, dr, rr_ptr
  );

endinterface

// File: rtl/flash_rr_arb.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request levels
//   en         : grant enable; gnt is only produced while en is high
//   gnt[1:0]   : one-hot grant (combinational)
//   ptr        : registered priority pointer, the port not granted last
//                (resets to port 0)
module flash_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       ptr
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
      // After serving port n, priority passes to the other port.
      if (|req) ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/flash_bus_arb.sv
// Arbiter and cycle sequencer for the shared asynchronous NOR flash bus.
// Grants one single-word access at a time to port 0 (JTAG flasher) or
// port 1 (CPU), generates oe_n/we_n strobes with parameterised timing,
// registers read data and synchronises the flash ready/busy line.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   bus                : master handshake bundle (slave side)
//   flash_adr          : flash word address
//   flash_d_i/d_o/d_oe : data pad in/out/output-enable
//   flash_oe_n/we_n    : flash strobes
//   flash_sts          : asynchronous ready/busy from the flash
//   sts_ready          : flash_sts after a 2-flop synchroniser
//   busy               : sequencer not idle
module flash_bus_arb
  import flash_bus_pkg::*;
#(
  parameter int ADR_WIDTH = DEF_ADR_WIDTH,
  parameter int RD_CYCLES = DEF_RD_CYCLES,
  parameter int WR_SETUP  = DEF_WR_SETUP,
  parameter int WR_PULSE  = DEF_WR_PULSE,
  parameter int WR_HOLD   = DEF_WR_HOLD
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  flash_bus_arb_if.slave        bus,
  output logic [ADR_WIDTH-1:0]  flash_adr,
  input  logic [DATA_WIDTH-1:0] flash_d_i,
  output logic [DATA_WIDTH-1:0] flash_d_o,
  output logic                  flash_d_oe,
  output logic                  flash_oe_n,
  output logic                  flash_we_n,
  input  logic                  flash_sts,
  output logic                  sts_ready,
  output logic                  busy
);

  state_e                state_q, state_d;
  cnt_t                  cnt_q, cnt_d;
  logic                  port_q, port_d;
  logic [ADR_WIDTH-1:0]  adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [DATA_WIDTH-1:0] dr_q, dr_d;
  logic                  sts_meta_q, sts_meta_d;
  logic                  sts_sync_q, sts_sync_d;
  logic [1:0]            gnt;
  logic                  arb_en;
  logic                  win_we;
  logic                  rr_ptr;

  assign arb_en = (state_q == ST_IDLE);

  flash_rr_arb u_rr (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .req   ({bus.req1, bus.req0}),
    .en    (arb_en),
    .gnt   (gnt),
    .ptr   (rr_ptr)
  );

  assign win_we = gnt[1] ? bus.we1 : bus.we0;

  // Next-state logic. The phase counter is reloaded on every state entry and
  // a timed phase ends in the cycle where the counter reads 1.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    port_d     = port_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    dr_d       = dr_q;
    sts_meta_d = flash_sts;
    sts_sync_d = sts_meta_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          port_d = gnt[1];
          adr_d  = gnt[1] ? bus.adr1 : bus.adr0;
          dat_d  = gnt[1] ? bus.dw1 : bus.dw0;
          if (win_we) begin
            state_d = ST_WS;
            cnt_d   = phase_len(WR_SETUP);
          end else begin
            state_d = ST_RD;
            cnt_d   = phase_len(RD_CYCLES);
          end
        end
      end
      ST_RD: begin
        if (cnt_q == cnt_t'(1)) begin
          dr_d    = flash_d_i;
          state_d = ST_ACK;
          cnt_d   = cnt_t'(1);
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      ST_WS: begin
        if (cnt_q == cnt_t'(1)) begin
          state_d = ST_WP;
          cnt_d   = phase_len(WR_PULSE);
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      ST_WP: begin
        if (cnt_q == cnt_t'(1)) begin
          state_d = ST_WH;
          cnt_d   = phase_len(WR_HOLD);
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      ST_WH: begin
        if (cnt_q == cnt_t'(1)) begin
          state_d = ST_ACK;
          cnt_d   = cnt_t'(1);
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        cnt_d   = cnt_t'(1);
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = cnt_t'(1);
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= cnt_t'(1);
      port_q     <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      dr_q       <= '0;
      sts_meta_q <= 1'b0;
      sts_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      port_q     <= port_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      dr_q       <= dr_d;
      sts_meta_q <= sts_meta_d;
      sts_sync_q <= sts_sync_d;
    end
  end

  // Strobes decode straight from the state register so that an asynchronous
  // reset releases the bus immediately, and oe_n/we_n can never overlap.
  assign flash_oe_n = (state_q != ST_RD);
  assign flash_we_n = (state_q != ST_WP);
  assign flash_d_oe = (state_q == ST_WS) || (state_q == ST_WP) || (state_q == ST_WH);
  assign busy       = (state_q != ST_IDLE);
  assign flash_adr  = adr_q;
  assign flash_d_o  = dat_q;
  assign sts_ready  = sts_sync_q;

  assign bus.ack0   = (state_q == ST_ACK) && !port_q;
  assign bus.ack1   = (state_q == ST_ACK) && port_q;
  assign bus.dr     = dr_q;
  assign bus.rr_ptr = rr_ptr;

endmodule
